// File: rtl/demod_pkg.sv
// Shared defaults and types for the demodulator front end and its channel scheduler.
package demod_pkg;

    localparam int DEF_N_CH = 4;
    localparam int DEF_DW   = 24;
    localparam int DEF_CW   = $clog2(DEF_N_CH);

    typedef logic [DEF_CW-1:0]        ch_idx_t;
    typedef logic signed [DEF_DW-1:0] sample_t;

    // Wraps an index that is known to be below 2*n back into 0..n-1.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/demod_ch_sched_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping N_CH-1 -> 0.
module rr_pick
    import demod_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic            gnt_valid,
    output logic [CW-1:0]   gnt_idx
);

    always_comb begin
        int          idx;
        logic [CW-1:0] idx_c;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_c     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx   = wrap_idx(int'(ptr) + i, N_CH);
            idx_c = CW'(idx);
            if (!gnt_valid && req[idx_c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx_c;
            end
        end
    end

endmodule

// File: rtl/demod_ch_sched.sv
// Round-robin scheduler sharing one demodulator stream between N_CH buffered ADC channels.
module demod_ch_sched
    import demod_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int DW   = DEF_DW,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_aresetn,
    input  logic [N_CH*DW-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]    s_axis_tvalid,
    output logic [N_CH-1:0]    s_axis_tready,
    input  logic [N_CH-1:0]    ch_enable,
    output logic [DW-1:0]      m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [CW-1:0]      m_axis_tuser,
    output logic               busy
);

    // A transfer happens on a rising edge where tvalid and tready are both high;
    // tvalid never waits on tready, and a raised tvalid holds its data until that edge.

    logic [N_CH-1:0] buf_valid;
    logic [DW-1:0]   buf_data [N_CH];
    logic [CW-1:0]   rr_ptr;
    logic            load;
    logic            gnt_valid;
    logic [CW-1:0]   gnt_idx;

    // Ready depends only on registers and config, never on m_axis_tready.
    assign s_axis_tready = ~buf_valid | ~ch_enable;
    assign load          = ~m_axis_tvalid | m_axis_tready;
    assign busy          = (|buf_valid) | m_axis_tvalid;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req       (buf_valid & ch_enable),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            buf_valid <= '0;
            for (int k = 0; k < N_CH; k++) begin
                buf_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                // A disabled channel keeps its ready high and drops whatever arrives.
                if (!ch_enable[k]) begin
                    buf_valid[k] <= 1'b0;
                end else if (s_axis_tvalid[k] && s_axis_tready[k]) begin
                    buf_valid[k] <= 1'b1;
                    buf_data[k]  <= s_axis_tdata[k*DW +: DW];
                end else if (load && gnt_valid && (gnt_idx == CW'(k))) begin
                    buf_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            if (gnt_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= buf_data[gnt_idx];
                m_axis_tuser  <= gnt_idx;
                rr_ptr        <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demod_ch_sched.sv
// Directed bench for demod_ch_sched: a 4-channel instance plus a 3-channel instance for wrap.
module tb_demod_ch_sched;
    import demod_pkg::*;

    localparam int N = 4;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tready;
    logic [N-1:0]   ch_enable = '1;
    logic [W-1:0]   m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [1:0]     m_tuser;
    logic           busy;

    logic [3*W-1:0] s3_tdata = '0;
    logic [2:0]     s3_tvalid = '0;
    logic [2:0]     s3_tready;
    logic [2:0]     ch3_enable = 3'b111;
    logic [W-1:0]   m3_tdata;
    logic           m3_tvalid;
    logic           m3_tready = 1'b0;
    logic [1:0]     m3_tuser;
    logic           busy3;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    demod_ch_sched #(.N_CH(N), .DW(W)) u_dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .ch_enable(ch_enable),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tuser(m_tuser), .busy(busy)
    );

    demod_ch_sched #(.N_CH(3), .DW(W)) u_dut3 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(s3_tdata), .s_axis_tvalid(s3_tvalid), .s_axis_tready(s3_tready),
        .ch_enable(ch3_enable),
        .m_axis_tdata(m3_tdata), .m_axis_tvalid(m3_tvalid), .m_axis_tready(m3_tready),
        .m_axis_tuser(m3_tuser), .busy(busy3)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] d, input logic v);
        s_tdata[k*W +: W] = d;
        s_tvalid[k] = v;
    endtask

    task automatic set3(input int k, input logic [W-1:0] d, input logic v);
        s3_tdata[k*W +: W] = d;
        s3_tvalid[k] = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        s_tvalid = '0;
        s3_tvalid = '0;
        m_tready = 1'b0;
        m3_tready = 1'b0;
        ch_enable = '1;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        for (int k = 0; k < N; k++) set_ch(k, W'(32'hC00 + k), 1'b1);
        repeat (8) tick;
        checks++;
        if (s_tready !== 4'h0) begin errors++; $display("FAIL rst_pre_full got %h exp 0", s_tready); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid); end
        checks++;
        if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_tdata); end
        checks++;
        if (m_tuser !== 2'd0) begin errors++; $display("FAIL rst_tuser got %0d exp 0", m_tuser); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++;
        if (s_tready !== 4'hF) begin errors++; $display("FAIL rst_tready got %h exp f", s_tready); end
        s_tvalid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_tready = 1'b1;
        set_ch(1, 24'h0D0001, 1'b1);
        set_ch(0, 24'h0D0000, 1'b1);
        tick;
        s_tvalid = '0;
        tick;
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 2'd0, 24'h0D0000})
            begin errors++; $display("FAIL rst_first_grant got %b/%0d/%h exp 1/0/0d0000", m_tvalid, m_tuser, m_tdata); end
        tick;
        checks++;
        if ({m_tvalid, m_tuser} !== {1'b1, 2'd1})
            begin errors++; $display("FAIL rst_second_grant got %b/%0d exp 1/1", m_tvalid, m_tuser); end
    endtask

    task automatic test_single;
        do_reset;
        m_tready = 1'b1;
        set_ch(2, 24'h123456, 1'b1);
        tick;
        s_tvalid = '0;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", m_tvalid); end
        tick;
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 2'd2, 24'h123456})
            begin errors++; $display("FAIL single_out got %b/%0d/%h exp 1/2/123456", m_tvalid, m_tuser, m_tdata); end
        tick;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", m_tvalid); end
    endtask

    task automatic test_fairness;
        int idx[N];
        logic [N-1:0] fire;
        bit started;
        int cyc;
        do_reset;
        m_tready = 1'b1;
        started = 1'b0;
        cyc = 0;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            idx[k] = 0;
            set_ch(k, W'(100 * k), 1'b1);
        end
        for (int j = 0; j < 20; j++) exp_q.push_back({2'(j % 4), W'(100 * (j % 4) + j / 4)});
        while (exp_q.size() > 0 && cyc < 60) begin
            fire = s_tvalid & s_tready;
            tick;
            cyc++;
            for (int k = 0; k < N; k++) begin
                if (fire[k]) begin
                    idx[k]++;
                    set_ch(k, W'(100 * k + idx[k]), 1'b1);
                end
            end
            if (m_tvalid === 1'b1) begin
                started = 1'b1;
                checks++;
                if ({m_tuser, m_tdata} !== exp_q[0])
                    begin errors++; $display("FAIL fair_seq got %0d/%0d exp %0d/%0d", m_tuser, m_tdata, exp_q[0][W+1:W], exp_q[0][W-1:0]); end
                void'(exp_q.pop_front());
            end else if (started) begin
                checks++;
                errors++;
                $display("FAIL fair_bubble got tvalid 0 exp 1 at cycle %0d", cyc);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fair_timeout got %0d left exp 0", exp_q.size()); end
        s_tvalid = '0;
    endtask

    task automatic test_backpressure;
        do_reset;
        set_ch(1, 24'hA00001, 1'b1);
        set_ch(3, 24'hA00003, 1'b1);
        tick;
        set_ch(3, 24'hA00003, 1'b0);
        set_ch(1, 24'hB00001, 1'b1);
        tick;
        tick;
        s_tvalid = '0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 2'd1, 24'hA00001})
                begin errors++; $display("FAIL bp_hold got %b/%0d/%h exp 1/1/a00001", m_tvalid, m_tuser, m_tdata); end
            checks++;
            if ({s_tready[1], s_tready[3]} !== 2'b00)
                begin errors++; $display("FAIL bp_tready got %b%b exp 00", s_tready[1], s_tready[3]); end
            tick;
        end
        m_tready = 1'b1;
        tick;
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 2'd3, 24'hA00003})
            begin errors++; $display("FAIL bp_rel_ch3 got %b/%0d/%h exp 1/3/a00003", m_tvalid, m_tuser, m_tdata); end
        tick;
        checks++;
        if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, 2'd1, 24'hB00001})
            begin errors++; $display("FAIL bp_rel_ch1 got %b/%0d/%h exp 1/1/b00001", m_tvalid, m_tuser, m_tdata); end
        tick;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", m_tvalid); end
    endtask

    task automatic test_enable;
        int grants;
        int cyc;
        bit found;
        do_reset;
        m_tready = 1'b1;
        ch_enable = 4'b1011;
        for (int k = 0; k < N; k++) set_ch(k, W'(32'h500 + k), 1'b1);
        repeat (20) begin
            tick;
            checks++;
            if (s_tready[2] !== 1'b1) begin errors++; $display("FAIL en_tready2 got %b exp 1", s_tready[2]); end
            if (m_tvalid === 1'b1) begin
                checks++;
                if (m_tuser === 2'd2) begin errors++; $display("FAIL en_muted got tuser %0d exp not 2", m_tuser); end
            end
        end
        ch_enable = 4'b1111;
        tick;
        grants = 0;
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 20) begin
            tick;
            cyc++;
            if (m_tvalid === 1'b1) begin
                grants++;
                if (m_tuser === 2'd2) begin
                    found = 1'b1;
                    checks++;
                    if (m_tdata !== 24'h000502) begin errors++; $display("FAIL en_ch2_data got %h exp 000502", m_tdata); end
                end
            end
        end
        checks++;
        if (!found || grants > 4) begin errors++; $display("FAIL en_regrant got found %0d grants %0d exp found 1 grants<=4", found, grants); end
        s_tvalid = '0;
    endtask

    task automatic test_wrap3;
        do_reset;
        m3_tready = 1'b1;
        set3(1, 24'h300001, 1'b1);
        tick;
        s3_tvalid = '0;
        tick;
        checks++;
        if ({m3_tvalid, m3_tuser} !== {1'b1, 2'd1}) begin errors++; $display("FAIL w3_ch1 got %b/%0d exp 1/1", m3_tvalid, m3_tuser); end
        set3(0, 24'h310000, 1'b1);
        set3(2, 24'h310002, 1'b1);
        tick;
        s3_tvalid = '0;
        tick;
        checks++;
        if ({m3_tvalid, m3_tuser, m3_tdata} !== {1'b1, 2'd2, 24'h310002})
            begin errors++; $display("FAIL w3_first got %b/%0d/%h exp 1/2/310002", m3_tvalid, m3_tuser, m3_tdata); end
        tick;
        checks++;
        if ({m3_tvalid, m3_tuser, m3_tdata} !== {1'b1, 2'd0, 24'h310000})
            begin errors++; $display("FAIL w3_wrap got %b/%0d/%h exp 1/0/310000", m3_tvalid, m3_tuser, m3_tdata); end
        set3(0, 24'h320000, 1'b1);
        set3(1, 24'h320001, 1'b1);
        tick;
        s3_tvalid = '0;
        tick;
        checks++;
        if ({m3_tvalid, m3_tuser, m3_tdata} !== {1'b1, 2'd1, 24'h320001})
            begin errors++; $display("FAIL w3_ptr1 got %b/%0d/%h exp 1/1/320001", m3_tvalid, m3_tuser, m3_tdata); end
        tick;
        checks++;
        if ({m3_tvalid, m3_tuser} !== {1'b1, 2'd0}) begin errors++; $display("FAIL w3_last got %b/%0d exp 1/0", m3_tvalid, m3_tuser); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_enable;
        test_wrap3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
